// File: rtl/mul_share_ctrl.sv
// Two-requester round-robin sequencer for the shared shift-add multiplier datapath.
// Build option MUL_ZERO_BYPASS_EN: zero operands complete in IDLE without touching the datapath.
module mul_share_ctrl #(
  parameter int unsigned width = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic [width-1:0]     opa0,
  input  logic [width-1:0]     opb0,
  output logic                 ack0,
  output logic                 done0,
  output logic [2*width-1:0]   res0,
  input  logic                 req1,
  input  logic [width-1:0]     opa1,
  input  logic [width-1:0]     opb1,
  output logic                 ack1,
  output logic                 done1,
  output logic [2*width-1:0]   res1,
  output logic                 dp_load,
  output logic                 dp_busy,
  output logic [width-1:0]     dp_opa,
  output logic [width-1:0]     dp_opb,
  input  logic [2*width-1:0]   dp_mul,
  output logic                 ctrl_busy
);

  localparam int unsigned cw = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RUN     = 3'd2,
    CAPTURE = 3'd3,
    RESP    = 3'd4
  } state_t;

  state_t             state, state_d;
  logic [cw-1:0]      cnt, cnt_d;
  logic               prio, prio_d;   // requester that wins a tie
  logic               gnt, gnt_d;     // requester currently being served
  logic               ack0_d, ack1_d, done0_d, done1_d;
  logic               load_d, busy_d, ctrl_busy_d;
  logic [width-1:0]   opa_d, opb_d;
  logic [2*width-1:0] res0_d, res1_d;

  logic               win_c;
  logic [width-1:0]   sel_opa_c, sel_opb_c;

  // Single requester wins outright; a tie goes to the one not served last.
  assign win_c     = (req0 && req1) ? prio : req1;
  assign sel_opa_c = win_c ? opa1 : opa0;
  assign sel_opb_c = win_c ? opb1 : opb0;

`ifdef MUL_ZERO_BYPASS_EN
  logic zero_c;
  assign zero_c = (sel_opa_c == '0) || (sel_opb_c == '0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      prio      <= 1'b0;
      gnt       <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res0      <= '0;
      res1      <= '0;
      dp_load   <= 1'b0;
      dp_busy   <= 1'b0;
      dp_opa    <= '0;
      dp_opb    <= '0;
      ctrl_busy <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      prio      <= prio_d;
      gnt       <= gnt_d;
      ack0      <= ack0_d;
      ack1      <= ack1_d;
      done0     <= done0_d;
      done1     <= done1_d;
      res0      <= res0_d;
      res1      <= res1_d;
      dp_load   <= load_d;
      dp_busy   <= busy_d;
      dp_opa    <= opa_d;
      dp_opb    <= opb_d;
      ctrl_busy <= ctrl_busy_d;
    end
  end

  // Next state plus next value of every registered output.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    prio_d      = prio;
    gnt_d       = gnt;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    load_d      = 1'b0;
    busy_d      = 1'b0;
    opa_d       = dp_opa;
    opb_d       = dp_opb;
    res0_d      = res0;
    res1_d      = res1;
    ctrl_busy_d = 1'b0;

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d  = win_c;
          prio_d = ~win_c;
          ack0_d = ~win_c;
          ack1_d = win_c;
`ifdef MUL_ZERO_BYPASS_EN
          if (zero_c) begin
            done0_d = ~win_c;
            done1_d = win_c;
            if (win_c) res1_d = '0;
            else       res0_d = '0;
          end else
`endif
          begin
            opa_d   = sel_opa_c;
            opb_d   = sel_opb_c;
            load_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt + cw'(1);
        if (cnt == cw'(width - 1)) state_d = CAPTURE;
        else                       busy_d  = 1'b1;
      end
      CAPTURE: begin
        if (gnt) begin
          res1_d  = dp_mul;
          done1_d = 1'b1;
        end else begin
          res0_d  = dp_mul;
          done0_d = 1'b1;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ctrl_busy_d = (state_d != IDLE);
  end

endmodule
